// File: rtl/hpram_dma_arbiter.sv
// Arbitrates the single HyperRAM command port between camera writes and HDMI reads.
// Optional macro HPRAM_ARB_READ_PRIO_EN: fixed read priority instead of round-robin.
module hpram_dma_arbiter #(
  parameter int BURST_BEATS = 4,
  parameter int ADDR_W      = 22,
  parameter int GAP_CYC     = 2,
  parameter int RD_TIMEOUT  = 64
) (
  input  logic              I_dma_clk,
  input  logic              I_rst,
  input  logic              I_init_calib,
  input  logic              I_wr_req,
  input  logic [ADDR_W-1:0] I_wr_addr,
  input  logic [31:0]       I_wr_data,
  input  logic [3:0]        I_wr_mask,
  output logic              O_wr_pop,
  output logic              O_wr_gnt,
  input  logic              I_rd_req,
  input  logic [ADDR_W-1:0] I_rd_addr,
  output logic              O_rd_gnt,
  output logic              O_rd_valid,
  output logic [31:0]       O_rd_data,
  output logic              O_cmd,
  output logic              O_cmd_en,
  output logic [ADDR_W-1:0] O_addr,
  output logic [31:0]       O_wr_data,
  output logic [3:0]        O_data_mask,
  input  logic              I_rd_data_valid,
  input  logic [31:0]       I_rd_data,
  output logic              O_busy,
  output logic              O_rd_timeout
);

  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int TW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

  localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_BEATS - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST  = TW'(RD_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ARB, WR, RDC, RDW, GAP} state_t;

  // With no gap configured a finished burst returns straight to arbitration.
  localparam state_t POST_BURST = (GAP_CYC == 0) ? ARB : GAP;

  state_t        state;
  logic [BW-1:0] beat_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          last_wr;
  logic          pick_rd;

  always_comb begin
    pick_rd = 1'b0;
`ifdef HPRAM_ARB_READ_PRIO_EN
    pick_rd = I_rd_req;
`else
    pick_rd = I_rd_req && (!I_wr_req || last_wr);
`endif
  end

  always_ff @(posedge I_dma_clk) begin
    if (I_rst) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      tmo_cnt      <= '0;
      last_wr      <= 1'b1;
      O_wr_pop     <= 1'b0;
      O_wr_gnt     <= 1'b0;
      O_rd_gnt     <= 1'b0;
      O_rd_valid   <= 1'b0;
      O_rd_data    <= '0;
      O_cmd        <= 1'b0;
      O_cmd_en     <= 1'b0;
      O_addr       <= '0;
      O_wr_data    <= '0;
      O_data_mask  <= '0;
      O_busy       <= 1'b0;
      O_rd_timeout <= 1'b0;
    end else begin
      O_wr_gnt   <= 1'b0;
      O_rd_gnt   <= 1'b0;
      O_cmd_en   <= 1'b0;
      O_rd_valid <= 1'b0;
      if (!I_init_calib) begin
        // Calibration loss: drop to IDLE but still pass on a beat landing this cycle.
        state    <= IDLE;
        O_busy   <= 1'b0;
        O_wr_pop <= 1'b0;
        if (state == RDW && I_rd_data_valid) begin
          O_rd_valid <= 1'b1;
          O_rd_data  <= I_rd_data;
        end
      end else begin
        case (state)
          IDLE: state <= ARB;
          ARB: begin
            if (pick_rd) begin
              O_rd_gnt <= 1'b1;
              O_addr   <= I_rd_addr;
              O_busy   <= 1'b1;
              last_wr  <= 1'b0;
              state    <= RDC;
            end else if (I_wr_req) begin
              O_wr_gnt <= 1'b1;
              O_addr   <= I_wr_addr;
              O_wr_pop <= 1'b1;
              O_busy   <= 1'b1;
              beat_cnt <= '0;
              last_wr  <= 1'b1;
              state    <= WR;
            end
          end
          WR: begin
            O_wr_data   <= I_wr_data;
            O_data_mask <= I_wr_mask;
            O_cmd       <= 1'b1;
            O_cmd_en    <= (beat_cnt == '0);
            beat_cnt    <= beat_cnt + 1'b1;
            if (beat_cnt == BEAT_LAST) begin
              O_wr_pop <= 1'b0;
              gap_cnt  <= '0;
              O_busy   <= (POST_BURST != ARB);
              state    <= POST_BURST;
            end
          end
          RDC: begin
            O_cmd_en <= 1'b1;
            O_cmd    <= 1'b0;
            tmo_cnt  <= '0;
            beat_cnt <= '0;
            state    <= RDW;
          end
          RDW: begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (I_rd_data_valid) begin
              O_rd_valid <= 1'b1;
              O_rd_data  <= I_rd_data;
              beat_cnt   <= beat_cnt + 1'b1;
            end
            // A last beat arriving on the timeout cycle still completes the burst.
            if (I_rd_data_valid && beat_cnt == BEAT_LAST) begin
              gap_cnt <= '0;
              O_busy  <= (POST_BURST != ARB);
              state   <= POST_BURST;
            end else if (tmo_cnt == TMO_LAST) begin
              O_rd_timeout <= 1'b1;
              gap_cnt      <= '0;
              O_busy       <= (POST_BURST != ARB);
              state        <= POST_BURST;
            end
          end
          GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
              O_busy <= 1'b0;
              state  <= ARB;
            end
          end
          default: begin
            O_busy <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hpram_dma_arbiter.sv
// Scoreboard bench for hpram_dma_arbiter: stimulus pushes expected grants, commands
// and beats; a monitor pops and compares whenever the DUT presents them.
module tb_hpram_dma_arbiter;

  logic        I_dma_clk;
  logic        I_rst;
  logic        I_init_calib;
  logic        I_wr_req;
  logic [21:0] I_wr_addr;
  logic [31:0] I_wr_data;
  logic [3:0]  I_wr_mask;
  logic        O_wr_pop;
  logic        O_wr_gnt;
  logic        I_rd_req;
  logic [21:0] I_rd_addr;
  logic        O_rd_gnt;
  logic        O_rd_valid;
  logic [31:0] O_rd_data;
  logic        O_cmd;
  logic        O_cmd_en;
  logic [21:0] O_addr;
  logic [31:0] O_wr_data;
  logic [3:0]  O_data_mask;
  logic        I_rd_data_valid;
  logic [31:0] I_rd_data;
  logic        O_busy;
  logic        O_rd_timeout;

  hpram_dma_arbiter #(
    .BURST_BEATS(4),
    .ADDR_W(22),
    .GAP_CYC(2),
    .RD_TIMEOUT(64)
  ) dut (
    .I_dma_clk(I_dma_clk),
    .I_rst(I_rst),
    .I_init_calib(I_init_calib),
    .I_wr_req(I_wr_req),
    .I_wr_addr(I_wr_addr),
    .I_wr_data(I_wr_data),
    .I_wr_mask(I_wr_mask),
    .O_wr_pop(O_wr_pop),
    .O_wr_gnt(O_wr_gnt),
    .I_rd_req(I_rd_req),
    .I_rd_addr(I_rd_addr),
    .O_rd_gnt(O_rd_gnt),
    .O_rd_valid(O_rd_valid),
    .O_rd_data(O_rd_data),
    .O_cmd(O_cmd),
    .O_cmd_en(O_cmd_en),
    .O_addr(O_addr),
    .O_wr_data(O_wr_data),
    .O_data_mask(O_data_mask),
    .I_rd_data_valid(I_rd_data_valid),
    .I_rd_data(I_rd_data),
    .O_busy(O_busy),
    .O_rd_timeout(O_rd_timeout)
  );

  typedef struct {
    logic        cmd;
    logic [21:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } cmd_t;

  int errors = 0;
  int checks = 0;

  logic  gq[$];          // expected grant sequence, 1 = write
  cmd_t  cq[$];          // expected commands
  logic [31:0] rq[$];    // expected read beats
  logic [35:0] bq[$];    // expected write beats 1..B-1 as {mask, data}
  logic [35:0] wq[$];    // write FIFO contents
  int    widx = 0;
  logic  pop_s = 1'b0;

  int          resp_n = 4;
  logic [31:0] resp_data = 32'hB0;
  logic [31:0] exp_rd_next = 32'hB0;

  int gnt_cnt = 0;
  int pop_cnt = 0;

  initial begin
    I_dma_clk = 1'b0;
    forever #5 I_dma_clk = ~I_dma_clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_ctl"}, {O_wr_pop, O_wr_gnt, O_rd_gnt, O_rd_valid, O_cmd, O_cmd_en, O_busy, O_rd_timeout}, 0);
    chk({pfx, "_rdata"}, O_rd_data, 0);
    chk({pfx, "_wdata"}, {O_data_mask, O_wr_data}, 0);
    chk({pfx, "_addr"}, O_addr, 0);
  endtask

  // sel: 0 rd_gnt, 1 wr_gnt, 2 cmd_en, 3 rd_timeout, 4 not busy
  task automatic wait_for(input int sel, input string name, input int lim);
    int  n;
    bit  hit;
    n   = 0;
    hit = 0;
    while (!hit && n < lim) begin
      @(negedge I_dma_clk);
      n++;
      case (sel)
        0: hit = O_rd_gnt;
        1: hit = O_wr_gnt;
        2: hit = O_cmd_en;
        3: hit = O_rd_timeout;
        default: hit = !O_busy;
      endcase
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: event not seen within %0d cycles", name, lim);
    end
  endtask

  task automatic exp_rd(input logic [21:0] addr, input int nb);
    cmd_t c;
    c.cmd  = 1'b0;
    c.addr = addr;
    c.data = '0;
    c.mask = '0;
    gq.push_back(1'b0);
    cq.push_back(c);
    for (int k = 0; k < nb; k++) begin
      rq.push_back(exp_rd_next);
      exp_rd_next = exp_rd_next + 1;
    end
  endtask

  task automatic exp_wr(input logic [21:0] addr, input logic [31:0] base, input logic [3:0] m);
    cmd_t c;
    c.cmd  = 1'b1;
    c.addr = addr;
    c.data = base;
    c.mask = m;
    gq.push_back(1'b1);
    cq.push_back(c);
    for (int k = 0; k < 4; k++) begin
      wq.push_back({m, base + 32'(k)});
      if (k > 0) bq.push_back({m, base + 32'(k)});
    end
  endtask

  // Show-ahead write FIFO: a pop seen in one cycle advances the head after the edge.
  initial forever begin
    @(negedge I_dma_clk);
    pop_s = O_wr_pop;
  end

  initial begin
    I_wr_data = '0;
    I_wr_mask = '0;
    forever begin
      @(posedge I_dma_clk);
      #1;
      if (pop_s) widx++;
      if (widx < wq.size()) begin
        I_wr_data = wq[widx][31:0];
        I_wr_mask = wq[widx][35:32];
      end else begin
        I_wr_data = '0;
        I_wr_mask = '0;
      end
    end
  end

  // Memory responder: answers each read command with resp_n beats, one idle cycle apart.
  initial begin
    I_rd_data_valid = 1'b0;
    I_rd_data       = '0;
    forever begin
      @(negedge I_dma_clk);
      if (O_cmd_en && !O_cmd) begin
        for (int k = 0; k < resp_n; k++) begin
          @(posedge I_dma_clk);
          #1;
          I_rd_data_valid = 1'b1;
          I_rd_data       = resp_data;
          resp_data       = resp_data + 1;
          @(posedge I_dma_clk);
          #1;
          I_rd_data_valid = 1'b0;
          @(negedge I_dma_clk);
          chk("rd_latency", O_rd_valid, 1);
        end
      end
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_en;
    int   wr_left;
    cmd_t c;
    logic [35:0] b;
    prev_en = 1'b0;
    wr_left = 0;
    forever begin
      @(negedge I_dma_clk);
      if (O_wr_pop) pop_cnt++;
      if (O_wr_gnt || O_rd_gnt) begin
        gnt_cnt++;
        chk("grant_onehot", O_wr_gnt & O_rd_gnt, 0);
        if (gq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL grant_unexpected: got wr=%0b rd=%0b expected none", O_wr_gnt, O_rd_gnt);
        end else begin
          chk("grant_type", O_wr_gnt, gq.pop_front());
        end
      end
      if (O_cmd_en) begin
        chk("cmd_spacing", prev_en, 0);
        if (cq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cmd_unexpected: got cmd=%0b addr=%0h expected none", O_cmd, O_addr);
        end else begin
          c = cq.pop_front();
          chk("cmd_type", O_cmd, c.cmd);
          chk("cmd_addr", O_addr, c.addr);
          if (c.cmd) begin
            chk("wr_beat0", {O_data_mask, O_wr_data}, {c.mask, c.data});
            wr_left = 3;
          end
        end
      end else if (wr_left > 0) begin
        wr_left--;
        if (bq.size() != 0) begin
          b = bq.pop_front();
          chk("wr_beat", {O_data_mask, O_wr_data}, b);
        end
      end
      if (O_rd_valid) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_unexpected: got %0h expected none", O_rd_data);
        end else begin
          chk("rd_beat", O_rd_data, rq.pop_front());
        end
      end
      prev_en = O_cmd_en;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int cnt;
    int n;
    int p0;
    int g0;
    I_rst        = 1'b1;
    I_init_calib = 1'b0;
    I_wr_req     = 1'b0;
    I_rd_req     = 1'b0;
    I_wr_addr    = '0;
    I_rd_addr    = '0;
    repeat (3) @(posedge I_dma_clk);
    @(negedge I_dma_clk);
    check_zero("reset");
    @(posedge I_dma_clk);
    #1 I_rst = 1'b0;

    // Calibration not done: requests must be held off
    I_rd_req  = 1'b1;
    I_wr_req  = 1'b1;
    I_rd_addr = 22'h3FFFFC;
    I_wr_addr = 22'h000100;
    cnt = 0;
    repeat (50) begin
      @(negedge I_dma_clk);
      cnt += int'(O_cmd_en) + int'(O_wr_gnt) + int'(O_rd_gnt) + int'(O_busy);
    end
    chk("calib_hold", cnt, 0);

    // First tie after reset goes to read; the pending write follows
    exp_rd(22'h3FFFFC, 4);
    exp_wr(22'h000100, 32'hA0, 4'h0);
    @(posedge I_dma_clk);
    #1 I_init_calib = 1'b1;
    wait_for(0, "tie_rd_gnt", 20);
    I_rd_req = 1'b0;
    @(negedge I_dma_clk);
    chk("rdcmd_en", O_cmd_en, 1);
    chk("rdcmd_type", O_cmd, 0);
    p0 = pop_cnt;
    wait_for(1, "wr_gnt", 100);
    I_wr_req = 1'b0;
    wait_for(2, "wr_cmd", 10);
    repeat (3) @(negedge I_dma_clk);
    chk("busy_gap0", O_busy, 1);
    @(negedge I_dma_clk);
    chk("busy_gap1", O_busy, 1);
    @(negedge I_dma_clk);
    chk("busy_arb", O_busy, 0);
    chk("wr_pops", pop_cnt - p0, 4);
    chk("tmo_clear", O_rd_timeout, 0);

    // Both requesters held: 8 bursts
    I_rd_addr = 22'h000300;
    I_wr_addr = 22'h000200;
    for (int i = 0; i < 8; i++) begin
`ifdef HPRAM_ARB_READ_PRIO_EN
      exp_rd(22'h000300, 4);
`else
      if (i % 2 == 0) exp_rd(22'h000300, 4);
      else exp_wr(22'h000200, 32'hD000_0000 + 32'(i * 16), 4'(i));
`endif
    end
    g0 = gnt_cnt;
    @(posedge I_dma_clk);
    #1;
    I_rd_req = 1'b1;
    I_wr_req = 1'b1;
    n = 0;
    while (gnt_cnt < g0 + 8 && n < 2000) begin
      @(negedge I_dma_clk);
      n++;
    end
    I_rd_req = 1'b0;
    I_wr_req = 1'b0;
    chk("alt_grants", gnt_cnt - g0, 8);
    wait_for(4, "alt_idle", 100);
    chk("alt_tmo_clear", O_rd_timeout, 0);

    // Short read: timeout then the pending write is served
    resp_n    = 3;
    I_rd_addr = 22'h0003A0;
    I_wr_addr = 22'h000240;
    exp_rd(22'h0003A0, 3);
    exp_wr(22'h000240, 32'h0000_E100, 4'h3);
    @(posedge I_dma_clk);
    #1;
    I_rd_req = 1'b1;
    I_wr_req = 1'b1;
    wait_for(0, "tmo_rd_gnt", 20);
    I_rd_req = 1'b0;
    wait_for(2, "tmo_cmd", 5);
    n = 0;
    do begin
      @(negedge I_dma_clk);
      n++;
    end while (!O_rd_timeout && n < 200);
    chk("tmo_cycles", n, 64);
    wait_for(1, "tmo_wr_gnt", 20);
    I_wr_req = 1'b0;
    wait_for(4, "tmo_idle", 50);
    resp_n = 4;
    chk("tmo_sticky", O_rd_timeout, 1);

    // Reset while write beat 2 is on the output
    I_wr_addr = 22'h000400;
    exp_wr(22'h000400, 32'hE0, 4'hF);
    @(posedge I_dma_clk);
    #1 I_wr_req = 1'b1;
    wait_for(1, "rst_wr_gnt", 10);
    I_wr_req = 1'b0;
    wait_for(2, "rst_wr_cmd", 5);
    @(negedge I_dma_clk);
    void'(bq.pop_back());
    @(negedge I_dma_clk);
    I_rst = 1'b1;
    @(negedge I_dma_clk);
    check_zero("midrst");
    cnt = 0;
    repeat (3) begin
      @(negedge I_dma_clk);
      cnt += int'(O_wr_pop) + int'(O_rd_valid) + int'(O_busy) + int'(O_cmd_en);
    end
    chk("rst_hold", cnt, 0);
    wq.delete();
    widx = 0;
    @(posedge I_dma_clk);
    #1;
    I_rst     = 1'b0;
    I_wr_addr = 22'h0002A0;
    exp_wr(22'h0002A0, 32'hF0, 4'h9);
    I_wr_req  = 1'b1;
    wait_for(1, "post_rst_gnt", 10);
    I_wr_req = 1'b0;
    wait_for(4, "post_rst_idle", 20);
    repeat (2) @(negedge I_dma_clk);

    chk("left_grants", gq.size(), 0);
    chk("left_cmds", cq.size(), 0);
    chk("left_rd", rq.size(), 0);
    chk("left_wr", bq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
